inout_sram_streamer: RTL and testbench

INOUT_SRAM_STREAMER -- requirements
Module: inout_sram_streamer

---
 rtl/inout_sram_streamer.sv | 197 +++++++++++++++++++
 tb/tb_inout_sram_streamer.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/inout_sram_streamer.sv
// Streams a window of 16-bit words from a 1-cycle-latency SRAM into a
// valid/ready port, gating reads on credit in a small output skid FIFO.
module inout_sram_streamer #(
    parameter int MAX_WORDS  = 196608,
    parameter int FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [17:0] base_addr,
    input  logic [18:0] length,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic        mem_cs,
    output logic        mem_oe,
    output logic        mem_web,
    output logic [17:0] mem_addr,
    input  logic [31:0] mem_rdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_data,
    output logic        out_last
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        FIN
    } state_t;

    state_t state_q, state_d;

    logic [17:0] addr_q;
    logic [18:0] len_q;
    logic [18:0] issued_q;
    logic [18:0] out_idx_q;
    logic        oe_q;
    logic        err_q;
    logic [CW-1:0] cnt_q;
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [15:0] fifo_mem [FIFO_DEPTH];

    logic [19:0] end_addr;
    logic        start_req;
    logic        start_ok;
    logic        credit;
    logic        issue;
    logic        last_issue;
    logic        pop;
    logic        push;
    logic        pop_fifo;
    logic        fifo_empty;
    logic        unused_rdata_hi;

    assign unused_rdata_hi = ^mem_rdata[31:16];

    // Range check is done one bit wider than the sum so it can never wrap.
    assign end_addr  = {2'b00, base_addr} + {1'b0, length};
    assign start_ok  = (length != 19'd0) && (end_addr <= 20'(MAX_WORDS));
    assign start_req = (state_q == IDLE) && start;

    assign fifo_empty = (cnt_q == '0);
    assign out_valid  = !fifo_empty || oe_q;
    assign pop        = out_valid && out_ready;

    // The word returning this cycle already owns a slot; a pop frees one.
    assign credit = (32'(cnt_q) + 32'(oe_q) + 32'd1)
                    <= (32'(FIFO_DEPTH) + 32'(pop));

    // A returning word bypasses straight to the head when the FIFO is empty.
    assign push     = oe_q && !(fifo_empty && pop);
    assign pop_fifo = pop && !fifo_empty;

    assign last_issue = issue && (issued_q == len_q - 19'd1);

    assign out_data = !fifo_empty ? fifo_mem[rd_ptr_q]
                    : (oe_q ? mem_rdata[15:0] : 16'h0000);
    assign out_last = out_valid && (out_idx_q == len_q - 19'd1);

    assign mem_addr = addr_q;
    assign mem_oe   = oe_q;
    assign mem_web  = 1'b1;
    assign error    = err_q;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (start && start_ok) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (last_issue) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (pop && out_last) begin
                    state_d = FIN;
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        busy  = 1'b0;
        done  = 1'b0;
        issue = 1'b0;
        unique case (state_q)
            IDLE: begin
            end
            RUN: begin
                busy  = 1'b1;
                issue = (issued_q < len_q) && credit;
            end
            DRAIN: begin
                busy = 1'b1;
            end
            FIN: begin
                done = 1'b1;
            end
            default: begin
            end
        endcase
        mem_cs = issue;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr_q    <= '0;
            len_q     <= '0;
            issued_q  <= '0;
            out_idx_q <= '0;
            oe_q      <= 1'b0;
            err_q     <= 1'b0;
            cnt_q     <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
        end else begin
            err_q <= start_req && !start_ok;
            oe_q  <= issue;
            if (start_req && start_ok) begin
                addr_q    <= base_addr;
                len_q     <= length;
                issued_q  <= '0;
                out_idx_q <= '0;
            end else begin
                if (issue) begin
                    addr_q   <= addr_q + 18'd1;
                    issued_q <= issued_q + 19'd1;
                end
                if (pop) begin
                    out_idx_q <= out_idx_q + 19'd1;
                end
            end
            if (push) begin
                wr_ptr_q <= ptr_inc(wr_ptr_q);
            end
            if (pop_fifo) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            cnt_q <= cnt_q + CW'(push) - CW'(pop_fifo);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= mem_rdata[15:0];
        end
    end

endmodule

// File: tb/tb_inout_sram_streamer.sv
// Directed vector table plus multi-cycle sequences for inout_sram_streamer.
module tb_inout_sram_streamer;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [17:0] base_addr;
    logic [18:0] length;
    logic        busy, done, error;
    logic        mem_cs, mem_oe, mem_web;
    logic [17:0] mem_addr;
    logic [31:0] mem_rdata = '0;
    logic        out_valid, out_ready;
    logic [15:0] out_data;
    logic        out_last;

    int vectors = 0;
    int miscompares = 0;

    inout_sram_streamer #(.MAX_WORDS(196608), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .base_addr(base_addr), .length(length),
        .busy(busy), .done(done), .error(error),
        .mem_cs(mem_cs), .mem_oe(mem_oe), .mem_web(mem_web),
        .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_last(out_last)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] pat(input logic [17:0] a);
        return a[15:0] ^ 16'hA5C3;
    endfunction

    // Synchronous SRAM model with sign-extended read data.
    always @(posedge clk) begin
        if (mem_cs) begin
            mem_rdata <= {{16{pat(mem_addr)[15]}}, pat(mem_addr)};
        end
    end

    typedef struct {
        logic        st;
        logic [17:0] b;
        logic [18:0] l;
        logic        rdy;
        logic        busy, done, err, cs, oe;
        logic [17:0] addr;
        logic        vld;
        logic [15:0] data;
        logic        last;
    } vec_t;

    vec_t tbl[13];

    function automatic vec_t mk(
        logic st, logic [17:0] b, logic [18:0] l, logic rdy,
        logic bz, logic dn, logic er, logic cs, logic oe,
        logic [17:0] ad, logic v, logic [15:0] d, logic ls);
        vec_t r;
        r.st = st; r.b = b; r.l = l; r.rdy = rdy;
        r.busy = bz; r.done = dn; r.err = er; r.cs = cs; r.oe = oe;
        r.addr = ad; r.vld = v; r.data = d; r.last = ls;
        return r;
    endfunction

    function automatic logic [40:0] pack_act();
        return {busy, done, error, mem_cs, mem_oe, mem_addr,
                out_valid, out_data, out_last};
    endfunction

    function automatic logic [40:0] pack_exp(vec_t v);
        return {v.busy, v.done, v.err, v.cs, v.oe, v.addr,
                v.vld, v.data, v.last};
    endfunction

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    int        got_q[$];
    bit        last_q[$];
    int        dones, errs, addr_bad, occ_bad, stall_bad, web_bad;
    int        issued, done_cyc, last_hs_cyc, busy1;
    logic [17:0] last_iss;

    task automatic run_xfer(input logic [17:0] b, input logic [18:0] l,
                            input int mode, input int restart_at);
        int cyc, occ, idx;
        logic [17:0] exp_a;
        logic pv, pr, pl;
        logic [15:0] pd;
        got_q.delete(); last_q.delete();
        dones = 0; errs = 0; addr_bad = 0; occ_bad = 0;
        stall_bad = 0; web_bad = 0; issued = 0;
        done_cyc = -1; last_hs_cyc = -1; busy1 = 0;
        occ = 0; exp_a = b; pv = 0; pr = 0; pd = '0; pl = 0;
        @(negedge clk);
        start = 1'b1; base_addr = b; length = l; out_ready = 1'b1;
        cyc = 0;
        while (cyc < 400) begin
            @(negedge clk);
            cyc++;
            idx = (cyc - 1) % 4;
            out_ready = (mode == 0) ? 1'b1 : (idx == 0 || idx == 3);
            if (cyc == restart_at) begin
                start = 1'b1; base_addr = 18'h0; length = 19'd3;
            end else begin
                start = 1'b0;
            end
            #1;
            if (cyc == 1) busy1 = busy;
            if (!mem_web) web_bad++;
            if (mem_cs) begin
                if (mem_addr !== exp_a) addr_bad++;
                last_iss = mem_addr;
                exp_a++;
                issued++;
            end
            if (mem_oe) occ++;
            if (occ > DEPTH) occ_bad++;
            if (pv && !pr) begin
                if (!out_valid || out_data !== pd || out_last !== pl)
                    stall_bad++;
            end
            if (out_valid && out_ready) begin
                got_q.push_back(int'(out_data));
                last_q.push_back(out_last);
                if (out_last) last_hs_cyc = cyc;
                occ--;
            end
            if (error) errs++;
            if (done) begin
                dones++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            pv = out_valid; pr = out_ready; pd = out_data; pl = out_last;
            if (done_cyc >= 0 && cyc >= done_cyc + 3) break;
        end
        start = 1'b0;
    endtask

    task automatic check_xfer(input string n, input logic [17:0] b,
                              input int l);
        int bad_data;
        int bad_last;
        bad_data = 0; bad_last = 0;
        chk({n, "_busy1"}, 64'(busy1), 64'd1);
        chk({n, "_count"}, 64'(got_q.size()), 64'(l));
        for (int i = 0; i < got_q.size(); i++) begin
            if (got_q[i] != int'(pat(b + 18'(i)))) bad_data++;
            if (last_q[i] != (i == l - 1)) bad_last++;
        end
        chk({n, "_data"}, 64'(bad_data), 64'd0);
        chk({n, "_last"}, 64'(bad_last), 64'd0);
        chk({n, "_issued"}, 64'(issued), 64'(l));
        chk({n, "_addr"}, 64'(addr_bad), 64'd0);
        chk({n, "_dones"}, 64'(dones), 64'd1);
        chk({n, "_done_t"}, 64'(done_cyc - last_hs_cyc), 64'd1);
        chk({n, "_errs"}, 64'(errs), 64'd0);
        chk({n, "_credit"}, 64'(occ_bad), 64'd0);
        chk({n, "_stall"}, 64'(stall_bad), 64'd0);
        chk({n, "_web"}, 64'(web_bad), 64'd0);
    endtask

    initial begin
        int seen;
        rst_n = 1'b0; start = 1'b0; base_addr = '0;
        length = '0; out_ready = 1'b1;

        tbl[0]  = mk(1, 18'h10, 19'd4, 1, 0,0,0,0,0, 18'h00, 0, 16'h0000, 0);
        tbl[1]  = mk(0, 18'h10, 19'd4, 1, 1,0,0,1,0, 18'h10, 0, 16'h0000, 0);
        tbl[2]  = mk(0, 18'h10, 19'd4, 1, 1,0,0,1,1, 18'h11, 1, 16'hA5D3, 0);
        tbl[3]  = mk(0, 18'h10, 19'd4, 1, 1,0,0,1,1, 18'h12, 1, 16'hA5D2, 0);
        tbl[4]  = mk(0, 18'h10, 19'd4, 1, 1,0,0,1,1, 18'h13, 1, 16'hA5D1, 0);
        tbl[5]  = mk(0, 18'h10, 19'd4, 1, 1,0,0,0,1, 18'h14, 1, 16'hA5D0, 1);
        tbl[6]  = mk(0, 18'h10, 19'd4, 1, 0,1,0,0,0, 18'h14, 0, 16'h0000, 0);
        tbl[7]  = mk(0, 18'h10, 19'd4, 1, 0,0,0,0,0, 18'h14, 0, 16'h0000, 0);
        tbl[8]  = mk(1, 18'h0, 19'd0, 1, 0,0,0,0,0, 18'h14, 0, 16'h0000, 0);
        tbl[9]  = mk(0, 18'h0, 19'd0, 1, 0,0,1,0,0, 18'h14, 0, 16'h0000, 0);
        tbl[10] = mk(1, 18'h2FFFF, 19'd2, 1, 0,0,0,0,0, 18'h14, 0, 16'h0, 0);
        tbl[11] = mk(0, 18'h2FFFF, 19'd2, 1, 0,0,1,0,0, 18'h14, 0, 16'h0, 0);
        tbl[12] = mk(0, 18'h2FFFF, 19'd2, 1, 0,0,0,0,0, 18'h14, 0, 16'h0, 0);

        repeat (2) @(negedge clk);
        #1;
        chk("reset_state", 64'(pack_act()), 64'd0);
        chk("reset_web", 64'(mem_web), 64'd1);
        rst_n = 1'b1;

        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            start = tbl[i].st; base_addr = tbl[i].b;
            length = tbl[i].l; out_ready = tbl[i].rdy;
            #1;
            chk($sformatf("row%0d", i), 64'(pack_act()),
                64'(pack_exp(tbl[i])));
        end
        start = 1'b0;

        run_xfer(18'h2FFFE, 19'd2, 0, -1);
        check_xfer("top_edge", 18'h2FFFE, 2);
        chk("top_edge_lastaddr", 64'(last_iss), 64'h2FFFF);

        run_xfer(18'h40, 19'd8, 1, -1);
        check_xfer("ready_toggle", 18'h40, 8);

        run_xfer(18'h200, 19'd6, 0, 2);
        check_xfer("restart_ignored", 18'h200, 6);

        // Reset on the third word of a 16-word transfer.
        @(negedge clk);
        start = 1'b1; base_addr = 18'h80; length = 19'd16; out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("pre_reset_word", 64'(out_data), 64'(pat(18'h82)));
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        chk("mid_reset_state", 64'(pack_act()), 64'd0);
        chk("mid_reset_web", 64'(mem_web), 64'd1);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            #1;
            if (done || busy || out_valid || mem_cs) seen++;
        end
        chk("post_reset_quiet", 64'(seen), 64'd0);

        run_xfer(18'h100, 19'd5, 0, -1);
        check_xfer("after_reset", 18'h100, 5);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
